// File: rtl/ntt_sched.sv
// ntt_sched: round-robin scheduler that shares one NTT engine among NREQ
// requesters and muxes the engine's memory master onto the owner's bank.
// Optional watchdog: define NTT_SCHED_TIMEOUT_EN to build the timeout counter
// and sticky err flag; without it err is tied low and the FSM waits on done.
module ntt_sched #(
   parameter int NREQ    = 2,
   parameter int DEPTH   = 1024,
   parameter int SIZE    = 32,
   parameter int TIMEOUT = 65535,
   localparam int AW     = $clog2(DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req,
   output logic [NREQ-1:0]           ack,
   output logic [NREQ-1:0]           grant,
   output logic                      busy,
   output logic                      ntt_enable,
   input  logic                      ntt_busy,
   input  logic                      ntt_done,
   input  logic [AW-1:0]             m_addr_r,
   input  logic [AW-1:0]             m_addr_w,
   input  logic [SIZE-1:0]           m_D,
   input  logic                      m_WE,
   input  logic                      m_RE,
   output logic [SIZE-1:0]           m_Q,
   output logic                      m_valid,
   output logic [NREQ-1:0][AW-1:0]   s_addr_r,
   output logic [NREQ-1:0][AW-1:0]   s_addr_w,
   output logic [NREQ-1:0][SIZE-1:0] s_D,
   output logic [NREQ-1:0]           s_WE,
   output logic [NREQ-1:0]           s_RE,
   input  logic [NREQ-1:0][SIZE-1:0] s_Q,
   input  logic [NREQ-1:0]           s_valid,
   output logic                      err
);

   localparam int PW = $clog2(NREQ);

   // Reject unsupported configurations at elaboration time
   if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_chk
      $error("ntt_sched: NREQ must be 2..8 and TIMEOUT >= 1");
   end

   typedef enum logic [1:0] {IDLE, START, RUN, RELEASE} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic            en_q, en_d;
   logic [PW-1:0]   win_q, win_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [PW-1:0]   win;
   logic            to_hit;

   // Winner = requester with the smallest rotated distance from rr_q
   always_comb begin
      int best;
      int d;
      win  = '0;
      best = NREQ;
      d    = 0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i]) begin
            d = i - int'(rr_q);
            if (d < 0) d = d + NREQ;
            if (d < best) begin
               best = d;
               win  = PW'(i);
            end
         end
      end
   end

   // FSM next state; done (or watchdog) wins over busy in START
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ack_d   = '0;
      en_d    = 1'b0;
      win_d   = win_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               win_d   = win;
               grant_d = NREQ'(1) << win;
               state_d = START;
            end
         end
         START, RUN: begin
            if (ntt_done || to_hit) begin
               state_d      = RELEASE;
               grant_d      = '0;
               ack_d[win_q] = 1'b1;
            end else if (state_q == START) begin
               if (ntt_busy) state_d = RUN;
               else          en_d    = 1'b1;
            end
         end
         RELEASE: begin
            rr_d    = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ack_q   <= '0;
         en_q    <= 1'b0;
         win_q   <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ack_q   <= ack_d;
         en_q    <= en_d;
         win_q   <= win_d;
         rr_q    <= rr_d;
      end
   end

`ifdef NTT_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   assign to_hit = (cnt_q >= CW'(TIMEOUT));

   // Watchdog: held at zero in IDLE, counts through START/RUN; err is sticky
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (|req) err_d = 1'b0;
      end else if (state_q == START || state_q == RUN) begin
         if (to_hit && !ntt_done) err_d = 1'b1;
         else                     cnt_d = cnt_q + 1'b1;
      end
   end

   // Watchdog registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign to_hit = 1'b0;
   assign err    = 1'b0;
`endif

   // Combinational memory mux: only the granted bank sees the engine
   always_comb begin
      m_Q     = '0;
      m_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         s_addr_r[i] = grant_q[i] ? m_addr_r : '0;
         s_addr_w[i] = grant_q[i] ? m_addr_w : '0;
         s_D[i]      = grant_q[i] ? m_D      : '0;
         s_WE[i]     = grant_q[i] & m_WE;
         s_RE[i]     = grant_q[i] & m_RE;
         if (grant_q[i]) begin
            m_Q     = s_Q[i];
            m_valid = s_valid[i];
         end
      end
   end

   assign grant      = grant_q;
   assign ack        = ack_q;
   assign ntt_enable = en_q;
   assign busy       = (state_q != IDLE);

endmodule
